alu_slice_sequencer: RTL and testbench
======================================

Name: alu_slice_sequencer

Overview:
Initiator that drives one 4-bit 74381-style ALU slice to execute a WIDTH-bit operation, one nibble per clock, least significant nibble first. It supplies slice A/B/S/Cn and consumes slice F and the active-low P/G outputs. It ripples the carry between nibbles, assembles the result, and accumulates group propagate/generate. It sits between the board-level operand/op registers and the single external slice instance.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥ 8.
SLICES, WIDTH/4, derived nibble count; not overridden by users.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only in IDLE.
op  input  3  operation code, same encoding as the slice S input (000 CLEAR … 111 PRESET).
a  input  WIDTH  operand A, latched on an accepted start.
b  input  WIDTH  operand B, latched on an accepted start.
cin  input  1  carry-in to nibble 0 (1 = no borrow for subtract ops).
busy  output  1  high while nibbles are being processed.
done  output  1  one-cycle pulse: result, cout and group flags are valid.
result  output  WIDTH  assembled F; held until the next accepted start.
cout  output  1  carry out of the top nibble for ops 001/010/011; 0 for all other ops.
group_p_n  output  1  active-low group propagate over all nibbles.
group_g_n  output  1  active-low group generate over all nibbles.
slice_a  output  4  A nibble to the slice.
slice_b  output  4  B nibble to the slice.
slice_s  output  3  op to the slice.
slice_cn  output  1  carry to the slice.
slice_f  input  4  slice result.
slice_p_n  input  1  slice propagate, active low.
slice_g_n  input  1  slice generate, active low.

Behaviour:
- Reset (async, any state): state IDLE; busy=0, done=0, result=0, cout=0, group_p_n=1, group_g_n=1, slice_a=0, slice_b=0, slice_s=000, slice_cn=0, nibble counter=0.
- States: IDLE → RUN → DONE → IDLE.
- IDLE, start=1 at edge E0:
  - latch a, b, op, cin.
  - carry_reg=cin, k=0, accumulated p=1, accumulated g=0.
  - go to RUN; busy=1 from E0.
- RUN: slice outputs are purely registered-state driven.
  - slice_a=a_reg[4k+3:4k], slice_b=b_reg[4k+3:4k], slice_s=op_reg, slice_cn=carry_reg.
  - The slice is combinational, so F/P/G are sampled in the same cycle.
- At each RUN edge E(k+1):
  - result[4k+3:4k] ← slice_f.
  - With p=~slice_p_n and g=~slice_g_n: carry_reg ← g | (p & carry_reg); acc_g ← g | (p & acc_g); acc_p ← acc_p & p.
  - k increments.
  - At k=SLICES-1 go to DONE.
- Latency: done is high in the cycle after edge E_SLICES, i.e. exactly SLICES+1 edges after the accepted start (E0 → done visible after E5 for WIDTH=16).
- DONE, for one cycle:
  - done=1, busy=0.
  - cout=carry_reg if op_reg ∈ {001,010,011}, else 0.
  - group_p_n=~acc_p, group_g_n=~acc_g.
  - Then IDLE; the outputs hold their values.
- Outside RUN, the slice drive outputs are 0 and slice_s=000.
- start in RUN or DONE is ignored and not queued; a caller must re-assert start in IDLE.
- result is not cleared at start; partial nibbles are visible during RUN. Only done qualifies result.
- Reset mid-RUN aborts: no done pulse, all registers return to reset values.
- Operands changing after start have no effect; only latched copies are used.
- op=000 yields result 0. op=111 yields all ones.

Decomposition:
- Shared package alu_pkg:
  - op code constants OP_CLEAR, OP_B_MINUS_A, OP_A_MINUS_B, OP_A_PLUS_B, OP_XOR, OP_OR, OP_AND, OP_PRESET.
  - SLICE_W=4.
  - State encoding IDLE/RUN/DONE.
- One natural sub-module, alu_lookahead_step: combinational.
  - Inputs: slice_p_n, slice_g_n, carry, acc_p, acc_g.
  - Outputs: next carry, next acc_p, next acc_g.
  - It is reusable by a future 74182-style group unit.

Test Plan:
- Add with rollover: op=011, a=0x1234, b=0x0FFF, cin=0, start for one cycle. Required: done exactly 5 edges later, result=0x2233, cout=0; busy high for 4 cycles.
- Add with carry out: op=011, a=0xFFFF, b=0x0001, cin=0. Required: result=0x0000, cout=1, group_g_n=0.
- Subtract with borrow: op=010, a=0x0005, b=0x0007, cin=1. Required: result=0xFFFE, cout=0. Then op=001 with the same operands. Required: result=0x0002, cout=1.
- Logic op: op=100, a=0xF0F0, b=0xFF00. Required: result=0x0FF0, cout=0. Then op=000. Required: result=0x0000.
- Start while busy: a second start pulse 2 cycles after the first, with different operands. Required: ignored; a single done pulse with the first operation's result.
- Reset mid-operation: rst_n low at the 3rd RUN cycle. Required: immediately busy=0, result=0, slice_s=000; no done pulse. After release, a new add of 0x0001+0x0001 yields 0x0002.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 74381-style slice sequencer: op codes, nibble width
// and the sequencer state encoding.
package alu_pkg;

    localparam int SLICE_W = 4;

    localparam logic [2:0] OP_CLEAR     = 3'b000;
    localparam logic [2:0] OP_B_MINUS_A = 3'b001;
    localparam logic [2:0] OP_A_MINUS_B = 3'b010;
    localparam logic [2:0] OP_A_PLUS_B  = 3'b011;
    localparam logic [2:0] OP_XOR       = 3'b100;
    localparam logic [2:0] OP_OR        = 3'b101;
    localparam logic [2:0] OP_AND       = 3'b110;
    localparam logic [2:0] OP_PRESET    = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Only the three arithmetic codes produce a meaningful ripple carry.
    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_B_MINUS_A) || (op == OP_A_MINUS_B) || (op == OP_A_PLUS_B);
    endfunction

endpackage

// File: rtl/alu_slice_sequencer_if.sv
// Bus between the sequencer and one external 4-bit ALU slice.
interface alu_slice_sequencer_if;
    import alu_pkg::*;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [2:0]         slice_s;
    logic               slice_cn;
    logic [SLICE_W-1:0] slice_f;
    logic               slice_p_n;
    logic               slice_g_n;

    modport master (
        output slice_a, slice_b, slice_s, slice_cn,
        input  slice_f, slice_p_n, slice_g_n
    );

    modport slave (
        input  slice_a, slice_b, slice_s, slice_cn,
        output slice_f, slice_p_n, slice_g_n
    );

endinterface

// File: rtl/alu_lookahead_step.sv
// One carry/group-lookahead step: folds a slice's active-low P/G into the
// running carry and the accumulated group propagate/generate.
module alu_lookahead_step
    import alu_pkg::*;
(
    input  logic slice_p_n,
    input  logic slice_g_n,
    input  logic carry,
    input  logic acc_p,
    input  logic acc_g,
    output logic carry_next,
    output logic acc_p_next,
    output logic acc_g_next
);

    logic p;
    logic g;

    assign p = ~slice_p_n;
    assign g = ~slice_g_n;

    assign carry_next = g | (p & carry);
    assign acc_g_next = g | (p & acc_g);
    assign acc_p_next = acc_p & p;

endmodule

// File: rtl/alu_slice_sequencer.sv
// Drives one external 4-bit ALU slice through a WIDTH-bit operation, one
// nibble per clock, least significant nibble first.
module alu_slice_sequencer
    import alu_pkg::*;
#(
    parameter  int WIDTH  = 16,
    localparam int SLICES = WIDTH / SLICE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cin,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               cout,
    output logic               group_p_n,
    output logic               group_g_n,
    output state_e             fsm_state,
    alu_slice_sequencer_if.master slice
);

    // Request protocol: start is honoured only in IDLE and is never queued;
    // busy covers the nibble cycles, done pulses once when result/cout/flags are valid.

    localparam int K_W = (SLICES > 1) ? $clog2(SLICES) : 1;

    state_e state_q;
    state_e state_d;

    logic [SLICES-1:0][SLICE_W-1:0] a_q;
    logic [SLICES-1:0][SLICE_W-1:0] b_q;
    logic [SLICES-1:0][SLICE_W-1:0] result_q;
    logic [2:0]                     op_q;
    logic [K_W-1:0]                 k_q;
    logic                           carry_q;
    logic                           acc_p_q;
    logic                           acc_g_q;
    logic                           busy_q;
    logic                           done_q;
    logic                           cout_q;
    logic                           group_p_n_q;
    logic                           group_g_n_q;

    logic carry_nx;
    logic acc_p_nx;
    logic acc_g_nx;
    logic last_nibble;

    assign last_nibble = (k_q == K_W'(SLICES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)       state_d = ST_RUN;
            ST_RUN:  if (last_nibble) state_d = ST_DONE;
            ST_DONE:                  state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // Slice drive comes only from registered state, so the slice's
    // combinational F/P/G settle within the same cycle.
    always_comb begin
        slice.slice_a  = '0;
        slice.slice_b  = '0;
        slice.slice_s  = OP_CLEAR;
        slice.slice_cn = 1'b0;
        if (state_q == ST_RUN) begin
            slice.slice_a  = a_q[k_q];
            slice.slice_b  = b_q[k_q];
            slice.slice_s  = op_q;
            slice.slice_cn = carry_q;
        end
    end

    alu_lookahead_step u_lookahead (
        .slice_p_n  (slice.slice_p_n),
        .slice_g_n  (slice.slice_g_n),
        .carry      (carry_q),
        .acc_p      (acc_p_q),
        .acc_g      (acc_g_q),
        .carry_next (carry_nx),
        .acc_p_next (acc_p_nx),
        .acc_g_next (acc_g_nx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            op_q        <= OP_CLEAR;
            k_q         <= '0;
            carry_q     <= 1'b0;
            acc_p_q     <= 1'b1;
            acc_g_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cout_q      <= 1'b0;
            group_p_n_q <= 1'b1;
            group_g_n_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            busy_q <= (state_d == ST_RUN);
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op;
                        carry_q <= cin;
                        k_q     <= '0;
                        acc_p_q <= 1'b1;
                        acc_g_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    result_q[k_q] <= slice.slice_f;
                    carry_q       <= carry_nx;
                    acc_p_q       <= acc_p_nx;
                    acc_g_q       <= acc_g_nx;
                    k_q           <= last_nibble ? '0 : k_q + 1'b1;
                end
                ST_DONE: begin
                    done_q      <= 1'b1;
                    cout_q      <= is_arith(op_q) ? carry_q : 1'b0;
                    group_p_n_q <= ~acc_p_q;
                    group_g_n_q <= ~acc_g_q;
                end
                default: ;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign cout      = cout_q;
    assign group_p_n = group_p_n_q;
    assign group_g_n = group_g_n_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Bench for alu_slice_sequencer: a behavioural 74381 slice on the bus and a
// full-width arithmetic reference for every operation.
module tb_alu_slice_sequencer;
    import alu_pkg::*;

    localparam int W  = 16;
    localparam int NS = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         group_p_n;
    logic         group_g_n;
    state_e       fsm_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_slice_sequencer_if ifc ();

    alu_slice_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .cout      (cout),
        .group_p_n (group_p_n),
        .group_g_n (group_g_n),
        .fsm_state (fsm_state),
        .slice     (ifc)
    );

    // Behavioural 74381 slice: P/G are reported for arithmetic codes only.
    logic [3:0] sx, sy;
    logic [4:0] s_gen;
    always_comb begin
        sx            = ifc.slice_a;
        sy            = ifc.slice_b;
        s_gen         = '0;
        ifc.slice_f   = '0;
        ifc.slice_p_n = 1'b1;
        ifc.slice_g_n = 1'b1;
        case (ifc.slice_s)
            OP_B_MINUS_A, OP_A_MINUS_B, OP_A_PLUS_B: begin
                if (ifc.slice_s == OP_B_MINUS_A) sx = ~ifc.slice_a;
                if (ifc.slice_s == OP_A_MINUS_B) sy = ~ifc.slice_b;
                ifc.slice_f   = 4'(sx + sy + {3'b000, ifc.slice_cn});
                s_gen         = {1'b0, sx} + {1'b0, sy};
                ifc.slice_g_n = ~s_gen[4];
                ifc.slice_p_n = ~(&(sx | sy));
            end
            OP_XOR:    ifc.slice_f = ifc.slice_a ^ ifc.slice_b;
            OP_OR:     ifc.slice_f = ifc.slice_a | ifc.slice_b;
            OP_AND:    ifc.slice_f = ifc.slice_a & ifc.slice_b;
            OP_PRESET: ifc.slice_f = 4'hF;
            default:   ifc.slice_f = 4'h0;
        endcase
    end

    // Full-width reference: whole-word arithmetic, no nibble iteration.
    function automatic void ref_model(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                                      input logic ci, output logic [W-1:0] r, output logic co,
                                      output logic gp_n_e, output logic gg_n_e);
        logic [W-1:0] x, y;
        logic [W:0]   full, gen;
        x = av; y = bv; r = '0; co = 1'b0; gp_n_e = 1'b1; gg_n_e = 1'b1;
        case (o)
            OP_B_MINUS_A, OP_A_MINUS_B, OP_A_PLUS_B: begin
                if (o == OP_B_MINUS_A) x = ~av;
                if (o == OP_A_MINUS_B) y = ~bv;
                full   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
                gen    = {1'b0, x} + {1'b0, y};
                r      = full[W-1:0];
                co     = full[W];
                gp_n_e = ~(&(x | y));
                gg_n_e = ~gen[W];
            end
            OP_XOR:    r = av ^ bv;
            OP_OR:     r = av | bv;
            OP_AND:    r = av & bv;
            OP_PRESET: r = '1;
            default:   r = '0;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, cout, group_p_n, group_g_n} !== 5'b00011) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=00011", {busy, done, cout, group_p_n, group_g_n});
        end
        checks++;
        if (result !== '0) begin
            errors++;
            $display("FAIL reset_result got=%h exp=0000", result);
        end
        checks++;
        if ({ifc.slice_a, ifc.slice_b, ifc.slice_s, ifc.slice_cn} !== 12'h000 || fsm_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_slice_drive got=%h state=%0d exp=000 state=0",
                     {ifc.slice_a, ifc.slice_b, ifc.slice_s, ifc.slice_cn}, fsm_state);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One operation: start for one cycle, scramble inputs after acceptance,
    // then check latency, busy length, outputs and the held state afterwards.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic ci, input string name);
        logic [W-1:0] er;
        logic ec, ep, eg;
        int edges, busy_cycles;
        ref_model(o, av, bv, ci, er, ec, ep, eg);
        op = o; a = av; b = bv; cin = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op = 3'($urandom); a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        edges = 0;
        busy_cycles = busy ? 1 : 0;
        while (!done && edges < 20) begin
            @(negedge clk);
            edges++;
            if (busy) busy_cycles++;
        end
        checks++;
        if (edges !== NS + 1) begin
            errors++;
            $display("FAIL %s latency got=%0d exp=%0d", name, edges, NS + 1);
        end
        checks++;
        if (busy_cycles !== NS) begin
            errors++;
            $display("FAIL %s busy_cycles got=%0d exp=%0d", name, busy_cycles, NS);
        end
        checks++;
        if ({result, cout} !== {er, ec}) begin
            errors++;
            $display("FAIL %s result got=%h cout=%b exp=%h cout=%b", name, result, cout, er, ec);
        end
        checks++;
        if ({group_p_n, group_g_n} !== {ep, eg}) begin
            errors++;
            $display("FAIL %s group_pg got=%b%b exp=%b%b", name, group_p_n, group_g_n, ep, eg);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || result !== er || ifc.slice_s !== OP_CLEAR) begin
            errors++;
            $display("FAIL %s after_done got done=%b result=%h s=%b exp done=0 result=%h s=000",
                     name, done, result, ifc.slice_s, er);
        end
    endtask

    task automatic test_add();
        run_op(OP_A_PLUS_B, 16'h1234, 16'h0FFF, 1'b0, "add_rollover");
        run_op(OP_A_PLUS_B, 16'hFFFF, 16'h0001, 1'b0, "add_carry_out");
    endtask

    task automatic test_subtract();
        run_op(OP_A_MINUS_B, 16'h0005, 16'h0007, 1'b1, "a_minus_b_borrow");
        run_op(OP_B_MINUS_A, 16'h0005, 16'h0007, 1'b1, "b_minus_a");
    endtask

    task automatic test_logic();
        run_op(OP_XOR,    16'hF0F0, 16'hFF00, 1'b0, "xor");
        run_op(OP_CLEAR,  16'hF0F0, 16'hFF00, 1'b1, "clear");
        run_op(OP_PRESET, 16'h1234, 16'h5678, 1'b1, "preset");
    endtask

    task automatic test_start_while_busy();
        logic [W-1:0] er, got;
        logic ec, ep, eg;
        int pulses, done_edge;
        ref_model(OP_A_PLUS_B, 16'h1111, 16'h2222, 1'b0, er, ec, ep, eg);
        op = OP_A_PLUS_B; a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0; done_edge = 0; got = '0;
        for (int i = 1; i <= 12; i++) begin
            if (i == 2) begin
                op = OP_XOR; a = 16'hAAAA; b = 16'h5555; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                pulses++;
                done_edge = i;
                got = result;
            end
        end
        start = 1'b0;
        checks++;
        if (pulses !== 1 || done_edge !== NS + 1) begin
            errors++;
            $display("FAIL busy_start pulses got=%0d at=%0d exp=1 at=%0d", pulses, done_edge, NS + 1);
        end
        checks++;
        if (got !== er) begin
            errors++;
            $display("FAIL busy_start result got=%h exp=%h", got, er);
        end
    endtask

    task automatic test_reset_mid_run();
        int seen_done;
        op = OP_A_PLUS_B; a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen_done = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || result !== '0 || ifc.slice_s !== OP_CLEAR || fsm_state !== ST_IDLE) begin
            errors++;
            $display("FAIL mid_reset got busy=%b result=%h s=%b state=%0d exp busy=0 result=0000 s=000 state=0",
                     busy, result, ifc.slice_s, fsm_state);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            errors++;
            $display("FAIL mid_reset_done got=%0d exp=0", seen_done);
        end
        run_op(OP_A_PLUS_B, 16'h0001, 16'h0001, 1'b0, "post_reset_add");
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            run_op(3'($urandom_range(7, 0)), W'($urandom), W'($urandom), 1'($urandom_range(1, 0)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_subtract();
        test_logic();
        test_start_while_busy();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
